// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: handshake and payload bundle for the ID->EX ALU issue
// stage. The decode-side request and the EX-side ALU operands share one bundle.
// The stage itself binds to the slave modport. The environment (decode and EX
// together) binds to the master modport.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    // Decode -> stage
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;

    // Stage -> EX
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [4:0]      out_rd;
    logic            out_reg_wen;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        output in_ready, out_valid, alu_sel, alu_in1, alu_in2, out_rd,
               out_reg_wen, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
        input  in_ready, out_valid, alu_sel, alu_in1, alu_in2, out_rd,
               out_reg_wen, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX register stage for RV32I ALU instructions.
// Decodes the instruction into a 4-bit ALU select and two operands, then
// registers them behind a valid/ready handshake. A synchronous flush kills
// every held entry.
// Optional feature: define ALU_ISSUE_SKID_EN to add a one-entry skid buffer.
// With the skid buffer, in_ready is registered and no longer depends
// combinationally on out_ready.
// Only XLEN = 32 is supported.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_issue_stage_if.slave  bus
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // One EX-stage entry: everything the ALU and writeback need.
    typedef struct packed {
        alu_sel_e        sel;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [4:0]      rd;
        logic            reg_wen;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    entry_t dec;

    // Decode the offered instruction into an EX entry.
    always_comb begin
        // NOTE: every field gets a default first, so no path through the
        // case statements can leave a field unassigned and infer a latch.
        dec         = '0;
        dec.sel     = ALU_ADD;
        dec.rd      = instr[11:7];

        unique case (opcode)
            OPC_OP: begin
                dec.in1     = bus.in_rs1_data;
                dec.in2     = bus.in_rs2_data;
                dec.reg_wen = 1'b1;
                case ({f7, f3})
                    {F7_BASE, 3'b000}: dec.sel = ALU_ADD;
                    {F7_BASE, 3'b001}: dec.sel = ALU_SLL;
                    {F7_BASE, 3'b010}: dec.sel = ALU_SLT;
                    {F7_BASE, 3'b011}: dec.sel = ALU_SLTU;
                    {F7_BASE, 3'b100}: dec.sel = ALU_XOR;
                    {F7_BASE, 3'b101}: dec.sel = ALU_SRL;
                    {F7_BASE, 3'b110}: dec.sel = ALU_OR;
                    {F7_BASE, 3'b111}: dec.sel = ALU_AND;
                    {F7_ALT,  3'b000}: dec.sel = ALU_SUB;
                    {F7_ALT,  3'b101}: dec.sel = ALU_SRA;
                    default:           dec.illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                dec.in1     = bus.in_rs1_data;
                dec.in2     = imm_i;
                dec.reg_wen = 1'b1;
                case (f3)
                    3'b000: dec.sel = ALU_ADD;
                    3'b001: begin
                        if (f7 == F7_BASE) dec.sel = ALU_SLL;
                        else               dec.illegal = 1'b1;
                    end
                    3'b010: dec.sel = ALU_SLT;
                    3'b011: dec.sel = ALU_SLTU;
                    3'b100: dec.sel = ALU_XOR;
                    3'b101: begin
                        if (f7 == F7_BASE)     dec.sel = ALU_SRL;
                        else if (f7 == F7_ALT) dec.sel = ALU_SRA;
                        else                   dec.illegal = 1'b1;
                    end
                    3'b110: dec.sel = ALU_OR;
                    default: dec.sel = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                dec.sel     = ALU_PASS;
                dec.in2     = imm_u;
                dec.reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                dec.in1     = bus.in_pc;
                dec.in2     = imm_u;
                dec.reg_wen = 1'b1;
            end
            OPC_LOAD, OPC_JALR: begin
                dec.in1     = bus.in_rs1_data;
                dec.in2     = imm_i;
                dec.reg_wen = 1'b1;
            end
            OPC_STORE: begin
                dec.in1 = bus.in_rs1_data;
                dec.in2 = imm_s;
            end
            OPC_BRANCH: begin
                dec.in1 = bus.in_pc;
                dec.in2 = imm_b;
            end
            OPC_JAL: begin
                dec.in1     = bus.in_pc;
                dec.in2     = imm_j;
                dec.reg_wen = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // The ALU shifter only looks at a 5-bit shift amount; clear the rest so
        // EX never sees junk upper bits from rs2 or the I-immediate.
        if (dec.sel inside {ALU_SLL, ALU_SRL, ALU_SRA}) begin
            dec.in2 = {{(XLEN-5){1'b0}}, dec.in2[4:0]};
        end

        // Undecodable instructions still flow to EX, but as a harmless ADD 0+0.
        if (dec.illegal) begin
            dec.sel     = ALU_ADD;
            dec.in1     = '0;
            dec.in2     = '0;
            dec.reg_wen = 1'b0;
        end

        // x0 is hardwired to zero, so a write to it is dropped here.
        if (dec.rd == 5'd0) begin
            dec.reg_wen = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    entry_t out_q;
    entry_t out_d;
    logic   out_valid_q;
    logic   out_valid_d;
    logic   out_free;
    logic   in_xfer;

    // The output slot can take a new entry if it is empty or being drained.
    assign out_free = !out_valid_q || bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_q;
    entry_t skid_d;
    logic   skid_valid_q;
    logic   skid_valid_d;

    // Registered ready: the stage accepts whenever the skid slot is empty.
    assign bus.in_ready = !flush && !skid_valid_q;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    // Next state for the output slot and the skid slot. The skid entry always
    // drains before new input, which keeps instructions in order.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_free) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            if (out_free) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Skid slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    // Without a skid slot, ready follows the output slot combinationally.
    assign bus.in_ready = !flush && out_free;
    assign in_xfer      = bus.in_valid && bus.in_ready;

    // Next state for the single output slot. A load and a drain on the same
    // edge replace the entry with no bubble.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (in_xfer) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Output slot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the payload is reset along with the valid bit because EX
            // observes these registers directly and expects zeros after reset.
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here keep every register updating
            // from the pre-edge values, independent of statement order.
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.alu_sel     = out_q.sel;
    assign bus.alu_in1     = out_q.in1;
    assign bus.alu_in2     = out_q.in2;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_reg_wen = out_q.reg_wen;
    assign bus.out_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed, table-driven bench for alu_issue_stage.
// The decode vectors are applied back-to-back. Hand-written sequences then
// cover these cases: async reset, backpressure ordering, and flush.
module tb_alu_issue_stage;

    logic clk;
    logic rst_n;
    logic flush;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  sel;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic logic [127:0] pack_out();
        return {52'b0, bus.out_valid, bus.alu_sel, bus.alu_in1, bus.alu_in2,
                bus.out_rd, bus.out_reg_wen, bus.out_illegal};
    endfunction

    function automatic logic [127:0] pack_exp(input vec_t v);
        return {52'b0, 1'b1, v.sel, v.in1, v.in2, v.rd, v.wen, v.ill};
    endfunction

    // addi x3, x2, imm
    function automatic logic [31:0] addi_x3(input logic [11:0] imm);
        return {imm, 5'd2, 3'b000, 5'd3, 7'b0010011};
    endfunction

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid    = 1'b1;
        bus.in_instr    = instr;
        bus.in_pc       = pc;
        bus.in_rs1_data = rs1;
        bus.in_rs2_data = rs2;
    endtask

    // Watchdog: a hung run still ends with a failure line.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    localparam int N = 8;
`ifdef ALU_ISSUE_SKID_EN
    logic exp_ir [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    logic exp_ir [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

    initial begin
        int sent;
        int recv;

        //       name        instr          pc        rs1           rs2           sel    in1           in2           rd  wen ill
        vecs[0]  = '{"addi",     32'hFFF08093, 32'h0,    32'd5,        32'h0,        4'h0, 32'd5,        32'hFFFFFFFF, 5'd1,  1'b1, 1'b0};
        vecs[1]  = '{"sra_r",    32'h4020D1B3, 32'h0,    32'h80000000, 32'h00000123, 4'h7, 32'h80000000, 32'h3,        5'd3,  1'b1, 1'b0};
        vecs[2]  = '{"srai_bad", 32'h4240D193, 32'h0,    32'h1234,     32'h0,        4'h0, 32'h0,        32'h0,        5'd3,  1'b0, 1'b1};
        vecs[3]  = '{"lui",      32'h123450B7, 32'h0,    32'hDEAD,     32'h0,        4'hA, 32'h0,        32'h12345000, 5'd1,  1'b1, 1'b0};
        vecs[4]  = '{"lui_x0",   32'h12345037, 32'h0,    32'hDEAD,     32'h0,        4'hA, 32'h0,        32'h12345000, 5'd0,  1'b0, 1'b0};
        vecs[5]  = '{"add",      32'h007302B3, 32'h0,    32'd10,       32'd20,       4'h0, 32'd10,       32'd20,       5'd5,  1'b1, 1'b0};
        vecs[6]  = '{"sub",      32'h407302B3, 32'h0,    32'd10,       32'd20,       4'h1, 32'd10,       32'd20,       5'd5,  1'b1, 1'b0};
        vecs[7]  = '{"sll_mask", 32'h007312B3, 32'h0,    32'd1,        32'hFFFFFFE1, 4'h2, 32'd1,        32'h1,        5'd5,  1'b1, 1'b0};
        vecs[8]  = '{"slt",      32'h007322B3, 32'h0,    32'd3,        32'd4,        4'h3, 32'd3,        32'd4,        5'd5,  1'b1, 1'b0};
        vecs[9]  = '{"sltu",     32'h007332B3, 32'h0,    32'd3,        32'd4,        4'h4, 32'd3,        32'd4,        5'd5,  1'b1, 1'b0};
        vecs[10] = '{"xor",      32'h007342B3, 32'h0,    32'hF0,       32'h3C,       4'h5, 32'hF0,       32'h3C,       5'd5,  1'b1, 1'b0};
        vecs[11] = '{"srl_mask", 32'h007352B3, 32'h0,    32'hF0,       32'h25,       4'h6, 32'hF0,       32'h5,        5'd5,  1'b1, 1'b0};
        vecs[12] = '{"or",       32'h007362B3, 32'h0,    32'hF0,       32'h3C,       4'h8, 32'hF0,       32'h3C,       5'd5,  1'b1, 1'b0};
        vecs[13] = '{"and",      32'h007372B3, 32'h0,    32'hF0,       32'h3C,       4'h9, 32'hF0,       32'h3C,       5'd5,  1'b1, 1'b0};
        vecs[14] = '{"mul_bad",  32'h027302B3, 32'h0,    32'd10,       32'd20,       4'h0, 32'h0,        32'h0,        5'd5,  1'b0, 1'b1};
        vecs[15] = '{"auipc",    32'h80000117, 32'h1000, 32'h77,       32'h0,        4'h0, 32'h1000,     32'h80000000, 5'd2,  1'b1, 1'b0};
        vecs[16] = '{"lw",       32'hFFC4A403, 32'h0,    32'h100,      32'h0,        4'h0, 32'h100,      32'hFFFFFFFC, 5'd8,  1'b1, 1'b0};
        vecs[17] = '{"sw",       32'h0074A423, 32'h0,    32'h200,      32'h99,       4'h0, 32'h200,      32'h8,        5'd8,  1'b0, 1'b0};
        vecs[18] = '{"beq",      32'hFE208CE3, 32'h2000, 32'h1,        32'h2,        4'h0, 32'h2000,     32'hFFFFFFF8, 5'd25, 1'b0, 1'b0};
        vecs[19] = '{"jal",      32'h001000EF, 32'h3000, 32'h0,        32'h0,        4'h0, 32'h3000,     32'h800,      5'd1,  1'b1, 1'b0};
        vecs[20] = '{"jalr",     32'h004280E7, 32'h0,    32'h4000,     32'h0,        4'h0, 32'h4000,     32'h4,        5'd1,  1'b1, 1'b0};
        vecs[21] = '{"slli",     32'h01F09093, 32'h0,    32'd7,        32'h0,        4'h2, 32'd7,        32'h1F,       5'd1,  1'b1, 1'b0};
        vecs[22] = '{"srai",     32'h4040D093, 32'h0,    32'h80,       32'h0,        4'h7, 32'h80,       32'h4,        5'd1,  1'b1, 1'b0};
        vecs[23] = '{"bad_opc",  32'h0000007F, 32'h0,    32'h55,       32'h66,       4'h0, 32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
        vecs[24] = '{"ori",      32'h80006093, 32'h0,    32'h12,       32'h0,        4'h8, 32'h12,       32'hFFFFF800, 5'd1,  1'b1, 1'b0};

        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_instr    = '0;
        bus.in_pc       = '0;
        bus.in_rs1_data = '0;
        bus.in_rs2_data = '0;
        bus.out_ready   = 1'b0;

        #3;
        check("reset_state", pack_out(), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Decode table, issued back-to-back with EX always ready.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            offer(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check(vecs[i].name, pack_out(), pack_exp(vecs[i]));
        end

        // Async reset mid-stream: out_valid=1, no clock edge before the check.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", pack_out(), 128'h0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;

        // Backpressure: EX stalls for cycles 0-3, then drains.
        // The stream of addi imm=k must arrive as 1..N, in order.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 60 && recv < N; cyc++) begin
            @(negedge clk);
            offer(addi_x3(12'(sent + 1)), 32'h0, 32'h100, 32'h0);
            bus.in_valid  = (sent < N) && (cyc != 12);
            bus.out_ready = (cyc < 4) ? 1'b0 : ((cyc < 10) ? 1'b1 : (cyc % 3 != 0));
            #4;
            if (cyc < 7)
                check($sformatf("bp_in_ready_c%0d", cyc), bus.in_ready, exp_ir[cyc]);
            if (cyc >= 1 && cyc <= 3)
                check($sformatf("bp_hold_c%0d", cyc), {bus.out_valid, bus.alu_in2}, {1'b1, 32'd1});
            if (bus.out_valid && bus.out_ready) begin
                check($sformatf("bp_order_%0d", recv), bus.alu_in2, 32'(recv + 1));
                recv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        check("bp_count", 32'(recv), 32'(N));
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #4;
        check("bp_no_dup", bus.out_valid, 1'b0);

        // Flush: load A, offer B while stalled (lands in skid if present),
        // then flush while offering C.
        @(negedge clk);
        offer(addi_x3(12'h055), 32'h0, 32'h0, 32'h0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        offer(addi_x3(12'h066), 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        offer(addi_x3(12'h077), 32'h0, 32'h0, 32'h0);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        #4;
        check("flush_in_ready", bus.in_ready, 1'b0);
        check("flush_pre_valid", {bus.out_valid, bus.alu_in2}, {1'b1, 32'h55});
        @(posedge clk);
        #1;
        check("flush_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #4;
        check("flush_ready_back", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        check("flush_all_gone", bus.out_valid, 1'b0);

        // The stage recovers and issues normally after the flush.
        @(negedge clk);
        offer(addi_x3(12'h088), 32'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("post_flush", {bus.out_valid, bus.alu_in2, bus.out_rd}, {1'b1, 32'h88, 5'd3});
        @(negedge clk);
        bus.in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID→EX pipeline stage that produces the ALU's input interface.
- Each cycle it can accept one RV32I instruction with its PC and register-file operands from decode.
- It decodes the instruction into the 4-bit ALU select, muxes and masks the two ALU operands, and registers the result for the EX stage.
- A valid/ready handshake is used on both sides, plus a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all held entries; dominates every other input
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  stage can accept; a transfer happens when in_valid && in_ready
- in_instr  input  32  instruction word
- in_pc  input  32  instruction PC
- in_rs1_data  input  32  rs1 value
- in_rs2_data  input  32  rs2 value
- out_valid  output  1  EX-stage entry valid
- out_ready  input  1  EX consumes; a transfer happens when out_valid && out_ready
- alu_sel  output  4  ALU operation code
- alu_in1  output  32  ALU operand 1
- alu_in2  output  32  ALU operand 2
- out_rd  output  5  destination register
- out_reg_wen  output  1  instruction writes rd
- out_illegal  output  1  instruction not decodable

Behaviour:
- ALU select encoding:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU
  - 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND
  - 1010 PASS in2
- Reset (async, on rst_n low): out_valid=0, alu_sel=0000, alu_in1=alu_in2=0, out_rd=0, out_reg_wen=0, out_illegal=0. Any in-flight entry is discarded.
- Base pipeline:
  - One register stage; latency is 1 cycle from input transfer to out_valid.
  - in_ready = !flush && (!out_valid || out_ready). This path is combinational from out_ready.
  - On an input transfer, all outputs load on the next edge and out_valid=1.
  - If out_ready=1 and there is no input transfer, out_valid clears.
  - Outputs hold stable while out_valid && !out_ready.
- Decode (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]):
  - OP (0110011): in1=rs1, in2=rs2.
    - f7=0000000: f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - f7=0100000: f3 000 SUB, 101 SRA.
    - Any other f7/f3 pair is illegal.
  - OP-IMM (0010011): in1=rs1, in2=sign-extended I-immediate. f3 maps as for OP, with no SUB.
    - SLLI requires f7=0000000.
    - SRLI requires f7=0000000; SRAI requires f7=0100000.
    - Any other f7 on a shift-immediate is illegal.
  - Shift masking: for every shift (R or I form), in2 is masked to {27'b0, operand[4:0]}.
  - LUI (0110111): PASS, in1=0, in2={instr[31:12],12'b0}.
  - AUIPC (0010111): ADD, in1=pc, in2=U-immediate.
  - LOAD (0000011) and JALR (1100111): ADD, in1=rs1, in2=I-immediate.
  - STORE (0100011): ADD, in1=rs1, in2=S-immediate.
  - BRANCH (1100011): ADD, in1=pc, in2=B-immediate.
  - JAL (1101111): ADD, in1=pc, in2=J-immediate.
  - out_reg_wen:
    - 1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL and JALR.
    - 0 for STORE, BRANCH and illegal.
    - Forced to 0 when rd=0.
  - Unknown opcode or illegal funct: alu_sel=ADD, in1=in2=0, reg_wen=0, illegal=1, out_valid still asserted.
- Flush:
  - Next edge: out_valid=0. Data registers may keep stale values.
  - An input offered during the flush cycle is not accepted, because in_ready=0.
  - Flush coincident with out_ready=1: the entry counts as consumed by nobody. EX must ignore it.
- Simultaneous transfer (out_ready=1 and in_valid=1 with out_valid=1): the old entry leaves and the new one loads on the same edge, with no bubble.

Optional Feature:
- Macro ALU_ISSUE_SKID_EN.
- When defined:
  - A one-entry skid buffer is added. in_ready = !flush && !skid_valid, which is registered and independent of out_ready.
  - An input accepted while the output is stalled goes into the skid buffer.
  - When out_ready returns, the skid entry moves to the output on the next edge, and in_ready rises on that same edge.
  - Flush clears both entries.
  - Order is preserved, and sustained throughput stays at 1 per cycle.
- When undefined: single-register behaviour exactly as above.

Test Plan:
- Reset check: rst_n low mid-stream, with out_valid=1 → outputs go to reset values asynchronously, without waiting for clk.
- ADDI: instr 0xFFF08093 (addi x1,x1,-1), rs1=5 → next cycle alu_sel=0000, in1=5, in2=0xFFFFFFFF, rd=1, reg_wen=1.
- Shift mask and funct checks:
  - SRA R-form, rs2=0x00000123 → alu_sel=0111, in2=0x00000003.
  - SRAI with f7=0100001 → illegal=1, reg_wen=0.
- LUI and rd=0:
  - 0x123450B7 → alu_sel=1010, in2=0x12345000, in1=0.
  - Same instruction with rd=0 → reg_wen=0.
- Backpressure:
  - Hold out_ready=0 for 3 cycles with in_valid=1 → outputs stable; in_ready=0 in base build.
  - Skid build: in_ready falls only after the second accept.
  - In both builds, the sequence is delivered in order with none lost or duplicated.
- Flush: flush=1 with out_valid=1 and in_valid=1 → in_ready=0 that cycle, out_valid=0 next cycle, and the offered instruction is not accepted.
